// File: rtl/divide_pkg.sv
// divide_pkg: FSM encoding and reset-reciprocal helper for the programmable divider
package divide_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, CALC} state_t;
  function automatic logic [63:0] recip_const(input int frac, input int n);
    return (64'd1 << frac) / 64'(n);
  endfunction
endpackage

// File: rtl/divide_by_var_recip_seq.sv
// recip_seq: restoring division of 2^FRAC by n, one quotient bit per cycle
module recip_seq #(
  parameter int NWIDTH = 8,
  parameter int FRAC = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NWIDTH-1:0] n,
  output logic              busy,
  output logic              done,
  output logic [FRAC:0]     recip
);
  localparam int CW = $clog2(FRAC + 1);
  logic [CW-1:0] cnt;
  logic [NWIDTH-1:0] rem, div, rem_nx;
  logic [FRAC-1:0] q;
  logic [NWIDTH:0] sh;
  logic ge;
  // the dividend is a single 1 at bit FRAC; shift it in and trial-subtract
  always_comb begin
    sh = {rem, cnt == CW'(FRAC)};
    ge = sh >= {1'b0, div};
    rem_nx = NWIDTH'(ge ? sh - {1'b0, div} : sh);
    done = busy && cnt == '0;
    recip = {q, ge};
  end
  // iteration state: latch divisor on start, then FRAC+1 bit steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      div <= '0;
      q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(FRAC);
      rem <= '0;
      div <= n;
      q <= '0;
    end else if (busy) begin
      rem <= rem_nx;
      q <= recip[FRAC-1:0];
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
endmodule

// File: rtl/divide_by_var.sv
// divide_by_var: run-time programmable reciprocal divider with a 4-stage pipeline
module divide_by_var
  import divide_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NWIDTH = 8,
  parameter int FRAC = 18,
  parameter int DEFAULT_DIVISOR = 43,
  parameter int ROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWIDTH-1:0] i_divisor,
  input  logic              i_divisor_load,
  output logic              o_busy,
  input  logic [DWIDTH-1:0] i_dividend,
  input  logic              i_dividend_v,
  output logic              o_dividend_rdy,
  output logic [DWIDTH-1:0] o_quotient,
  output logic [NWIDTH-1:0] o_remainder,
  output logic              o_div_by_zero,
  output logic              o_quotient_v
);
  localparam int PROD_W = DWIDTH + FRAC + 1;
  localparam int RECIP_W = FRAC + 1;
  localparam int MUL_W = DWIDTH + NWIDTH;
  localparam int RW = NWIDTH + 1;
  localparam logic [RECIP_W-1:0] RECIP_RST = RECIP_W'(recip_const(FRAC, DEFAULT_DIVISOR));
  if (FRAC < DWIDTH) begin : g_frac_chk
    $error("FRAC must be >= DWIDTH");
  end
  if (DEFAULT_DIVISOR == 0) begin : g_div_chk
    $error("DEFAULT_DIVISOR must be non-zero");
  end
  state_t state;
  logic [NWIDTH-1:0] divisor, pending, n1, n2, n3, rc;
  logic [RECIP_W-1:0] recip, seq_recip;
  logic [DWIDTH-1:0] x1, x2, x3, q2, q3, qc;
  logic [PROD_W-1:0] p1;
  logic [RW-1:0] r3;
  logic v1, v2, v3, acc, drained, start, seq_busy, seq_done, ge, up;
  assign o_busy = state != RUN || seq_busy;
  assign o_dividend_rdy = !o_busy;
  assign acc = i_dividend_v && o_dividend_rdy;
  assign drained = !(v1 || v2 || v3 || o_quotient_v);
  assign start = state == DRAIN && drained && pending != '0 && pending != divisor;
  recip_seq #(.NWIDTH(NWIDTH), .FRAC(FRAC)) u_recip (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .n(pending),
    .busy(seq_busy),
    .done(seq_done),
    .recip(seq_recip)
  );
  // divisor-change sequencer: drain in-flight work, then rebuild the reciprocal
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      divisor <= NWIDTH'(DEFAULT_DIVISOR);
      pending <= '0;
      recip <= RECIP_RST;
    end else
      case (state)
        RUN: if (i_divisor_load) begin
          pending <= i_divisor;
          state <= DRAIN;
        end
        DRAIN: if (drained) begin
          state <= start ? CALC : RUN;
          if (!start) divisor <= pending;
        end
        CALC: if (seq_done) begin
          state <= RUN;
          divisor <= pending;
          recip <= seq_recip;
        end
        default: state <= RUN;
      endcase
  // one-step correction of the estimate, then optional round-to-nearest
  always_comb begin
    ge = r3 >= {1'b0, n3};
    rc = NWIDTH'(ge ? r3 - {1'b0, n3} : r3);
    up = ROUND != 0 && {rc, 1'b0} >= {1'b0, n3};
    qc = q3 + DWIDTH'(ge) + DWIDTH'(up);
  end
  // dividend pipeline; each stage carries the divisor it was issued with
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, v2, v3, o_quotient_v} <= '0;
      {x1, x2, x3, n1, n2, n3} <= '0;
      {p1, q2, q3, r3} <= '0;
      {o_quotient, o_remainder, o_div_by_zero} <= '0;
    end else begin
      v1 <= acc;
      x1 <= i_dividend;
      n1 <= divisor;
      p1 <= PROD_W'(i_dividend) * PROD_W'(recip);
      v2 <= v1;
      x2 <= x1;
      n2 <= n1;
      q2 <= DWIDTH'(p1 >> FRAC);
      v3 <= v2;
      x3 <= x2;
      n3 <= n2;
      q3 <= q2;
      r3 <= RW'(MUL_W'(x2) - MUL_W'(q2) * MUL_W'(n2));
      o_quotient_v <= v3;
      if (v3) begin
        o_quotient <= n3 == '0 ? '1 : qc;
        o_remainder <= n3 == '0 ? NWIDTH'(x3) : rc;
        o_div_by_zero <= n3 == '0;
      end
    end
endmodule

// File: tb/tb_divide_by_var.sv
// tb_divide_by_var: table vectors plus scoreboard against an arithmetic model
`timescale 1ns/1ps
module tb_divide_by_var;
  localparam int BUSY_FULL = 4 + 1 + 18 + 1;
  typedef struct {int q, r, z, due;} exp_t;
  typedef struct {int x, n, rnd, q, r, z;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] i_divisor = '0, i_dividend = '0;
  logic i_divisor_load = 1'b0, i_dividend_v = 1'b0;
  logic busy_r, rdy_r, dz_r, qv_r, busy_t, rdy_t, dz_t, qv_t;
  logic [7:0] q_r, rem_r, q_t, rem_t;
  exp_t sbr[$], sbt[$];
  vec_t tv[10];
  int n_cmp = 0, n_bad = 0, cyc = 0, model_n = 43;
  int last_q[2], last_r[2], last_z[2], got[2];
  always #5 clk = ~clk;
  divide_by_var #(.ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .i_divisor(i_divisor), .i_divisor_load(i_divisor_load),
    .o_busy(busy_r), .i_dividend(i_dividend), .i_dividend_v(i_dividend_v),
    .o_dividend_rdy(rdy_r), .o_quotient(q_r), .o_remainder(rem_r),
    .o_div_by_zero(dz_r), .o_quotient_v(qv_r)
  );
  divide_by_var #(.ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .i_divisor(i_divisor), .i_divisor_load(i_divisor_load),
    .o_busy(busy_t), .i_dividend(i_dividend), .i_dividend_v(i_dividend_v),
    .o_dividend_rdy(rdy_t), .o_quotient(q_t), .o_remainder(rem_t),
    .o_div_by_zero(dz_t), .o_quotient_v(qv_t)
  );
  function automatic exp_t model(int x, int n, int rnd);
    exp_t e;
    e.due = 0;
    if (n == 0) begin
      e.q = 255;
      e.r = x;
      e.z = 1;
    end else begin
      e.q = x / n;
      e.r = x % n;
      e.z = 0;
      if (rnd != 0 && 2 * e.r >= n) e.q++;
    end
    return e;
  endfunction
  task automatic check(input bit ok, input string name, input int act, input int want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask
  task automatic mon_one(input int d, input logic v, input int q, input int r, input int z);
    exp_t e;
    int sz;
    string tag;
    tag = d != 0 ? "trunc" : "round";
    sz = d != 0 ? sbt.size() : sbr.size();
    e = '{0, 0, 0, 0};
    if (sz > 0) e = d != 0 ? sbt[0] : sbr[0];
    if (v) begin
      got[d] = 1;
      last_q[d] = q;
      last_r[d] = r;
      last_z[d] = z;
      check(sz > 0, {tag, " result without accepted dividend"}, sz, 1);
      if (sz > 0) begin
        if (d != 0) e = sbt.pop_front();
        else e = sbr.pop_front();
        check(cyc == e.due, {tag, " latency"}, cyc, e.due);
        check(q == e.q, {tag, " quotient"}, q, e.q);
        check(r == e.r, {tag, " remainder"}, r, e.r);
        check(z == e.z, {tag, " div_by_zero"}, z, e.z);
      end
    end else if (sz > 0 && e.due <= cyc) begin
      check(v == 1'b1, {tag, " missing result"}, int'(v), 1);
      if (d != 0) e = sbt.pop_front();
      else e = sbr.pop_front();
    end
  endtask
  task automatic step();
    @(negedge clk);
    mon_one(0, qv_r, q_r, rem_r, dz_r);
    mon_one(1, qv_t, q_t, rem_t, dz_t);
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic drive(input int x, input bit v, input bit ld, input int nd);
    exp_t e;
    i_dividend = 8'(x);
    i_dividend_v = v;
    i_divisor_load = ld;
    i_divisor = 8'(nd);
    if (v && rdy_r) begin
      e = model(x, model_n, 1);
      e.due = cyc + 4;
      sbr.push_back(e);
      e = model(x, model_n, 0);
      e.due = cyc + 4;
      sbt.push_back(e);
    end
    if (ld && !busy_r) model_n = nd;
    step();
    i_dividend_v = 1'b0;
    i_divisor_load = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) drive(0, 1'b0, 1'b0, 0);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy_r && k < 200) begin
      idle(1);
      k++;
    end
    check(!busy_r, "busy timeout", int'(busy_r), 0);
  endtask
  task automatic load_div(input int nd);
    wait_idle();
    drive(0, 1'b0, 1'b1, nd);
    wait_idle();
  endtask
  task automatic vec_check(input vec_t t);
    int d;
    d = t.rnd != 0 ? 0 : 1;
    got[0] = 0;
    got[1] = 0;
    drive(t.x, 1'b1, 1'b0, 0);
    idle(5);
    check(got[d] == 1, $sformatf("vec x=%0d n=%0d arrived", t.x, t.n), got[d], 1);
    check(last_q[d] == t.q, $sformatf("vec x=%0d n=%0d q", t.x, t.n), last_q[d], t.q);
    check(last_r[d] == t.r, $sformatf("vec x=%0d n=%0d r", t.x, t.n), last_r[d], t.r);
    check(last_z[d] == t.z, $sformatf("vec x=%0d n=%0d z", t.x, t.n), last_z[d], t.z);
  endtask
  initial begin
    int bc;
    tv = '{'{100, 7, 1, 14, 2, 0}, '{5, 2, 1, 3, 1, 0}, '{4, 2, 1, 2, 0, 0},
           '{77, 0, 1, 255, 77, 1}, '{77, 10, 1, 8, 7, 0}, '{255, 1, 0, 255, 0, 0},
           '{255, 255, 0, 1, 0, 0}, '{200, 43, 1, 5, 28, 0}, '{255, 43, 1, 6, 40, 0},
           '{0, 43, 1, 0, 0, 0}};
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(qv_r == 1'b0, "reset quotient_v", int'(qv_r), 0);
    check(q_r == 8'd0, "reset quotient", int'(q_r), 0);
    check(rem_r == 8'd0, "reset remainder", int'(rem_r), 0);
    check(dz_r == 1'b0, "reset div_by_zero", int'(dz_r), 0);
    check(busy_r == 1'b0, "reset busy", int'(busy_r), 0);
    check(rdy_r == 1'b1, "reset ready", int'(rdy_r), 1);
    rst_n = 1'b1;
    idle(2);
    drive(200, 1'b1, 1'b0, 0);
    drive(255, 1'b1, 1'b0, 0);
    drive(0, 1'b1, 1'b0, 0);
    drive(50, 1'b1, 1'b1, 7);
    bc = 0;
    while (busy_r && bc < 100) begin
      drive(int'($urandom_range(0, 255)), 1'b1, bc == 10, 99);
      bc++;
    end
    check(bc == BUSY_FULL, "busy cycles after load with full pipeline", bc, BUSY_FULL);
    foreach (tv[i]) begin
      if (tv[i].n != model_n) load_div(tv[i].n);
      vec_check(tv[i]);
    end
    drive(200, 1'b1, 1'b0, 0);
    idle(5);
    drive(0, 1'b0, 1'b1, 3);
    idle(8);
    check(busy_r == 1'b1, "busy before mid-calc reset", int'(busy_r), 1);
    #2 rst_n = 1'b0;
    #1;
    check(q_r == 8'd0, "mid-calc reset quotient", int'(q_r), 0);
    check(rem_r == 8'd0, "mid-calc reset remainder", int'(rem_r), 0);
    check(qv_r == 1'b0, "mid-calc reset quotient_v", int'(qv_r), 0);
    check(busy_r == 1'b0, "mid-calc reset busy", int'(busy_r), 0);
    sbr.delete();
    sbt.delete();
    model_n = 43;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    vec_check('{86, 43, 1, 2, 0, 0});
    for (int n = 1; n < 256; n++) begin
      load_div(n);
      for (int x = 0; x < 256; x++) drive(x, 1'b1, 1'b0, 0);
    end
    repeat (2000)
      drive(int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 255)));
    idle(8);
    check(sbr.size() == 0, "round results outstanding", sbr.size(), 0);
    check(sbt.size() == 0, "trunc results outstanding", sbt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
